pll_ctrl: RTL and testbench

PLL_CTRL -- requirements
Module: pll_ctrl

---
 rtl/pll_ctrl_if.sv | 11 +
 rtl/pll_ctrl.sv | 131 +++++++++++++
 tb/tb_pll_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_if.sv
// Configuration handshake between a requester and pll_ctrl:
// a level request with phase/duty payload, answered by a one-cycle ack.
interface pll_ctrl_if;
   logic       cfg_req;
   logic [3:0] cfg_psda;
   logic [3:0] cfg_duty;
   logic       cfg_ack;

   modport master (output cfg_req, output cfg_psda, output cfg_duty, input cfg_ack);
   modport slave  (input cfg_req, input cfg_psda, input cfg_duty, output cfg_ack);
endinterface

// File: rtl/pll_ctrl.sv
// pll_ctrl: sequences an rPLL through reset, lock qualification, run and
// post-reconfiguration settling. Retries a bounded number of times before
// latching a fault that only rst_n can clear.
module pll_ctrl #(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned LOCK_FILTER   = 64,
   parameter int unsigned LOCK_TIMEOUT  = 65535,
   parameter int unsigned MAX_RETRY     = 3,
   parameter int unsigned SETTLE_CYCLES = 32
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       pll_reset_p,
   output logic [3:0] psda,
   output logic [3:0] dutyda,
   pll_ctrl_if.slave  cfg,
   output logic       ready,
   output logic       fault,
   output logic [1:0] retry_cnt
);

   localparam int unsigned RW = (RST_CYCLES    > 1) ? $clog2(RST_CYCLES)    : 1;
   localparam int unsigned FW = (LOCK_FILTER   > 1) ? $clog2(LOCK_FILTER)   : 1;
   localparam int unsigned TW = (LOCK_TIMEOUT  > 1) ? $clog2(LOCK_TIMEOUT)  : 1;
   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [RW-1:0] RST_LAST    = RW'(RST_CYCLES - 1);
   localparam logic [FW-1:0] FILT_LAST   = FW'(LOCK_FILTER - 1);
   localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_RESET, S_WAIT_LOCK, S_RUN, S_SETTLE, S_FAULT
   } state_t;

   state_t        state, state_d;
   logic [1:0]    sync_q;
   logic          lock;
   logic [RW-1:0] rst_cnt, rst_cnt_d;
   logic [FW-1:0] lock_cnt, lock_cnt_d;
   logic [TW-1:0] to_cnt, to_cnt_d;
   logic [SW-1:0] settle_cnt, settle_cnt_d;
   logic [1:0]    retry_d, retry_inc;
   logic [3:0]    psda_d, duty_d;

   assign lock        = sync_q[1];
   assign pll_reset   = (state == S_RESET) || (state == S_FAULT);
   assign pll_reset_p = pll_reset;
   assign ready       = (state == S_RUN);
   assign fault       = (state == S_FAULT);

   // Next-state, counter and setting updates; counters fall back to zero
   // whenever their state is not the one using them.
   always_comb begin
      state_d      = state;
      rst_cnt_d    = '0;
      lock_cnt_d   = '0;
      to_cnt_d     = '0;
      settle_cnt_d = '0;
      retry_d      = retry_cnt;
      psda_d       = psda;
      duty_d       = dutyda;
      cfg.cfg_ack  = 1'b0;
      retry_inc    = (retry_cnt == 2'd3) ? 2'd3 : retry_cnt + 2'd1;

      case (state)
         S_RESET: begin
            if (rst_cnt == RST_LAST) state_d = S_WAIT_LOCK;
            else                     rst_cnt_d = rst_cnt + RW'(1);
         end
         S_WAIT_LOCK: begin
            // qualified lock is tested first so it wins over a same-cycle timeout
            if (lock && (lock_cnt == FILT_LAST)) begin
               state_d = S_RUN;
               retry_d = '0;
            end else if (to_cnt == TO_LAST) begin
               retry_d = retry_inc;
               state_d = (32'(retry_inc) == MAX_RETRY) ? S_FAULT : S_RESET;
            end else begin
               lock_cnt_d = lock ? lock_cnt + FW'(1) : '0;
               to_cnt_d   = to_cnt + TW'(1);
            end
         end
         S_RUN: begin
            if (!lock) begin
               state_d = S_RESET;
            end else if (cfg.cfg_req) begin
               psda_d      = cfg.cfg_psda;
               duty_d      = cfg.cfg_duty;
               cfg.cfg_ack = 1'b1;
               state_d     = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (!lock)                            state_d = S_RESET;
            else if (settle_cnt == SETTLE_LAST)   state_d = S_RUN;
            else                                  settle_cnt_d = settle_cnt + SW'(1);
         end
         S_FAULT: ;
         default: state_d = S_RESET;
      endcase
   end

   // State, counters, lock synchronizer and applied settings.
   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_RESET;
         sync_q     <= '0;
         rst_cnt    <= '0;
         lock_cnt   <= '0;
         to_cnt     <= '0;
         settle_cnt <= '0;
         retry_cnt  <= '0;
         psda       <= 4'b0000;
         dutyda     <= 4'b1000;
      end else begin
         state      <= state_d;
         sync_q     <= {sync_q[0], pll_lock};
         rst_cnt    <= rst_cnt_d;
         lock_cnt   <= lock_cnt_d;
         to_cnt     <= to_cnt_d;
         settle_cnt <= settle_cnt_d;
         retry_cnt  <= retry_d;
         psda       <= psda_d;
         dutyda     <= duty_d;
      end
   end

endmodule

// File: tb/tb_pll_ctrl.sv
// tb_pll_ctrl: directed scenarios plus randomized lock/config traffic, all
// checked each cycle against a countdown-based reference model.
module tb_pll_ctrl;

   localparam int unsigned RSTC = 16;
   localparam int unsigned FILT = 64;
   localparam int unsigned TOUT = 100;
   localparam int unsigned MAXR = 3;
   localparam int unsigned SETL = 32;

   localparam int P_HOLD = 0, P_WAIT = 1, P_RUN = 2, P_SETTLE = 3, P_FAULT = 4;

   logic       clkin = 1'b0;
   logic       rst_n = 1'b1;
   logic       pll_lock = 1'b0;
   logic       pll_reset, pll_reset_p, ready, fault;
   logic [3:0] psda, dutyda;
   logic [1:0] retry_cnt;
   logic       pll_reset_l, pll_reset_p_l, ready_l, fault_l;
   logic [3:0] psda_l, dutyda_l;
   logic [1:0] retry_cnt_l;

   int n_cmp = 0;
   int n_bad = 0;

   pll_ctrl_if cfg();
   pll_ctrl_if cfg_l();

   assign cfg_l.cfg_req  = cfg.cfg_req;
   assign cfg_l.cfg_psda = cfg.cfg_psda;
   assign cfg_l.cfg_duty = cfg.cfg_duty;

   pll_ctrl #(.RST_CYCLES(RSTC), .LOCK_FILTER(FILT), .LOCK_TIMEOUT(TOUT),
              .MAX_RETRY(MAXR), .SETTLE_CYCLES(SETL)) dut (
      .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock),
      .pll_reset(pll_reset), .pll_reset_p(pll_reset_p),
      .psda(psda), .dutyda(dutyda), .cfg(cfg),
      .ready(ready), .fault(fault), .retry_cnt(retry_cnt)
   );

   // Second instance with the default (long) timeout, used where lock
   // qualification needs more than TOUT cycles.
   pll_ctrl #(.RST_CYCLES(RSTC), .LOCK_FILTER(FILT),
              .MAX_RETRY(MAXR), .SETTLE_CYCLES(SETL)) dut_long (
      .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock),
      .pll_reset(pll_reset_l), .pll_reset_p(pll_reset_p_l),
      .psda(psda_l), .dutyda(dutyda_l), .cfg(cfg_l),
      .ready(ready_l), .fault(fault_l), .retry_cnt(retry_cnt_l)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      int          phase;
      int unsigned hold_left;
      int unsigned waited;
      int unsigned streak;
      int unsigned settle_left;
      int unsigned fails;
      logic [3:0]  ps;
      logic [3:0]  du;
      logic        h0;   // raw lock seen at the latest edge
      logic        h1;   // raw lock seen one edge earlier = lock the controller acts on
   } model_t;

   model_t m;

   function automatic model_t fresh();
      model_t r;
      r.phase = P_HOLD; r.hold_left = RSTC; r.waited = 0; r.streak = 0;
      r.settle_left = 0; r.fails = 0; r.ps = 4'h0; r.du = 4'h8;
      r.h0 = 1'b0; r.h1 = 1'b0;
      return r;
   endfunction

   function automatic model_t step(model_t c, logic raw, logic req,
                                   logic [3:0] ps, logic [3:0] du);
      model_t n = c;
      logic   lk = c.h1;
      case (c.phase)
         P_HOLD: begin
            n.hold_left = c.hold_left - 1;
            if (n.hold_left == 0) begin
               n.phase = P_WAIT; n.waited = 0; n.streak = 0;
            end
         end
         P_WAIT: begin
            n.waited = c.waited + 1;
            n.streak = lk ? c.streak + 1 : 0;
            if (n.streak == FILT) begin
               n.phase = P_RUN; n.fails = 0;
            end else if (n.waited == TOUT) begin
               n.fails = (c.fails < 3) ? c.fails + 1 : 3;
               if (n.fails == MAXR) n.phase = P_FAULT;
               else begin n.phase = P_HOLD; n.hold_left = RSTC; end
            end
         end
         P_RUN: begin
            if (!lk) begin
               n.phase = P_HOLD; n.hold_left = RSTC;
            end else if (req) begin
               n.ps = ps; n.du = du; n.phase = P_SETTLE; n.settle_left = SETL;
            end
         end
         P_SETTLE: begin
            if (!lk) begin
               n.phase = P_HOLD; n.hold_left = RSTC;
            end else begin
               n.settle_left = c.settle_left - 1;
               if (n.settle_left == 0) n.phase = P_RUN;
            end
         end
         default: ;
      endcase
      n.h1 = c.h0;
      n.h0 = raw;
      return n;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   // Reference model advances on every edge, or resets with the DUT.
   always @(posedge clkin or negedge rst_n) begin
      if (!rst_n) m <= fresh();
      else        m <= step(m, pll_lock, cfg.cfg_req, cfg.cfg_psda, cfg.cfg_duty);
   end

   // Every cycle: compare all DUT outputs against the model, mid-cycle.
   always @(negedge clkin) begin
      chk("pll_reset",   32'(pll_reset),   32'(m.phase == P_HOLD || m.phase == P_FAULT));
      chk("pll_reset_p", 32'(pll_reset_p), 32'(m.phase == P_HOLD || m.phase == P_FAULT));
      chk("ready",       32'(ready),       32'(m.phase == P_RUN));
      chk("fault",       32'(fault),       32'(m.phase == P_FAULT));
      chk("retry_cnt",   32'(retry_cnt),   m.fails);
      chk("psda",        32'(psda),        32'(m.ps));
      chk("dutyda",      32'(dutyda),      32'(m.du));
      chk("cfg_ack",     32'(cfg.cfg_ack), 32'(m.phase == P_RUN && m.h1 && cfg.cfg_req));
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got still running, want finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          n, first_fall;
      int unsigned prev;
      int unsigned rq[$];
      int unsigned low_left;
      logic        ack_seen;

      cfg.cfg_req = 1'b0; cfg.cfg_psda = 4'h0; cfg.cfg_duty = 4'h0;
      #1 rst_n = 1'b0;
      tick(); tick();
      chk("rst pll_reset", 32'(pll_reset), 1);
      chk("rst psda",      32'(psda),      0);
      chk("rst dutyda",    32'(dutyda),    8);
      chk("rst ready",     32'(ready),     0);
      chk("rst fault",     32'(fault),     0);
      chk("rst retry",     32'(retry_cnt), 0);
      rst_n = 1'b1;

      // Lock arrives 10 cycles after reset release of the PLL.
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 100);
      chk("reset length", n, RSTC);
      repeat (10) tick();
      pll_lock = 1'b1;
      n = 0;
      while (!ready && n < 500) begin tick(); n++; end
      chk("lock to ready", n, 66);
      chk("retry after lock", 32'(retry_cnt), 0);

      // Reconfiguration in RUN.
      cfg.cfg_req = 1'b1; cfg.cfg_psda = 4'h5; cfg.cfg_duty = 4'h6;
      #1 chk("cfg ack pulse", 32'(cfg.cfg_ack), 1);
      tick();
      cfg.cfg_req = 1'b0;
      chk("ack after accept", 32'(cfg.cfg_ack), 0);
      chk("psda applied",     32'(psda),   5);
      chk("dutyda applied",   32'(dutyda), 6);
      n = 1;
      while (!ready && n < 100) begin tick(); if (!ready) n++; end
      chk("settle length", n, SETL);

      // Lock loss coincident with a request.
      pll_lock = 1'b0;
      tick(); tick();
      cfg.cfg_req = 1'b1; cfg.cfg_psda = 4'h9; cfg.cfg_duty = 4'h3;
      #1 chk("ack on lock loss", 32'(cfg.cfg_ack), 0);
      tick();
      chk("reset on lock loss", 32'(pll_reset), 1);
      chk("psda kept",          32'(psda),      5);
      chk("retry kept",         32'(retry_cnt), 0);
      cfg.cfg_req = 1'b0;

      // Single-cycle glitch at filter count 40 restarts qualification.
      n = 0;
      do begin tick(); n++; end while (pll_reset && n < 100);
      pll_lock = 1'b1;
      n = 0;
      repeat (40) begin tick(); n++; end
      pll_lock = 1'b0;
      tick(); n++;
      pll_lock = 1'b1;
      while (!ready_l && n < 300) begin tick(); n++; end
      chk("glitch lock to ready", n, 107);
      n = 0;
      while (!ready && n < 300) begin tick(); n++; end
      chk("short dut relocks", 32'(ready), 1);

      // Asynchronous reset in SETTLE, then a lock that never comes.
      cfg.cfg_req = 1'b1; cfg.cfg_psda = 4'hA; cfg.cfg_duty = 4'h3;
      tick();
      cfg.cfg_req = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      pll_lock = 1'b0;
      #1;
      chk("async pll_reset", 32'(pll_reset), 1);
      chk("async psda",      32'(psda),      0);
      chk("async dutyda",    32'(dutyda),    8);
      chk("async ready",     32'(ready),     0);
      tick();
      rst_n = 1'b1;
      n = 0; first_fall = 0; prev = 0;
      while (!fault && n < 1000) begin
         tick(); n++;
         if (!pll_reset && first_fall == 0) first_fall = n;
         if (int'(retry_cnt) != prev) begin
            prev = int'(retry_cnt);
            rq.push_back(prev);
         end
      end
      chk("restart reset length", first_fall, RSTC);
      chk("cycles to fault", n, 348);
      chk("retry steps", rq.size(), 3);
      for (int i = 0; i < rq.size() && i < 3; i++)
         chk("retry step value", rq[i], i + 1);
      chk("fault pll_reset", 32'(pll_reset), 1);
      chk("fault retry",     32'(retry_cnt), 3);
      pll_lock = 1'b1;
      cfg.cfg_req = 1'b1;
      repeat (150) tick();
      chk("fault held", 32'(fault), 1);
      chk("fault no ack", 32'(cfg.cfg_ack), 0);
      cfg.cfg_req = 1'b0;

      // Randomized lock behaviour, requests and resets.
      low_left = 0;
      ack_seen = 1'b0;
      for (int i = 0; i < 8000; i++) begin
         tick();
         if (!rst_n) begin
            rst_n = 1'b1;
         end else if (m.phase == P_FAULT || $urandom_range(0, 2999) == 0) begin
            rst_n = 1'b0;
            cfg.cfg_req = 1'b0;
         end
         if (low_left > 0) begin
            pll_lock = 1'b0;
            low_left--;
         end else begin
            pll_lock = 1'b1;
            if ($urandom_range(0, 299) == 0)      low_left = $urandom_range(1, 3);
            else if ($urandom_range(0, 799) == 0) low_left = $urandom_range(50, 300);
         end
         if (cfg.cfg_req && ack_seen) begin
            cfg.cfg_req = 1'b0;
         end else if (!cfg.cfg_req && rst_n && $urandom_range(0, 15) == 0) begin
            cfg.cfg_req  = 1'b1;
            cfg.cfg_psda = 4'($urandom_range(0, 15));
            cfg.cfg_duty = 4'($urandom_range(0, 15));
         end
         #2 ack_seen = cfg.cfg_ack;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
